squeeze_stream: RTL
===================

// Module: squeeze_stream
// PURPOSE
//  Multi-block SHAKE squeeze engine. Streams an arbitrary-length XOF output as WORD_WIDTH words over valid/ready.
//  Captures the rate portion of the Keccak state. Requests a new permutation from the permutation core each time a rate block is exhausted.
//  Sits between keccak permutation core and the output interface/top-level controller.
// PARAMETERS
//  RATE         1088  rate in bits (SHAKE256); must be a multiple of WORD_WIDTH
//  STATE_WIDTH  1600  Keccak state width in bits
//  WORD_WIDTH   64    output word width in bits
//  LEN_WIDTH    16    width of requested output length (in words)
//  derived: WPB = RATE/WORD_WIDTH (17 by default); IDX_W = $clog2(WPB)
// PORTS
//  clk            in   1            clock, rising edge
//  reset_n        in   1            synchronous reset, active low
//  squeeze_start  in   1            start pulse; sampled only in IDLE
//  out_len_words  in   LEN_WIDTH    number of output words; sampled with squeeze_start
//  state_in       in   STATE_WIDTH  current Keccak state from permutation core
//  perm_req       out  1            one-cycle pulse: permute state_in again
//  perm_done      in   1            permutation complete; state_in valid this cycle
//  out_word       out  WORD_WIDTH   output word, little-endian lane order
//  out_valid      out  1            out_word valid
//  out_ready      in   1            consumer accepts out_word
//  out_last       out  1            current word is the final word of the request
//  busy           out  1            high in every state except IDLE
//  squeeze_done   out  1            one-cycle pulse when request complete
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): FSM->IDLE; all outputs 0; rate buffer, idx and remaining count cleared.
//  Reset mid-operation aborts immediately. No further perm_req. No squeeze_done.
//  FSM states:
//   IDLE -> STREAM when squeeze_start && out_len_words!=0. In that cycle: buf<=state_in[RATE-1:0], idx<=0, rem<=out_len_words.
//   IDLE -> DONE when squeeze_start && out_len_words==0. Produces no words.
//   STREAM: out_valid=1; out_word=buf[idx*WORD_WIDTH +: WORD_WIDTH]; out_last=(rem==1).
//     Handshake on out_valid&&out_ready: rem<=rem-1, idx<=idx+1.
//     After a handshake with rem==1 -> DONE.
//     After a handshake with idx==WPB-1 and rem>1 -> PERM_REQ.
//     out_word and out_last are held stable while out_valid && !out_ready.
//   PERM_REQ: perm_req=1 for exactly this cycle; out_valid=0 -> PERM_WAIT.
//   PERM_WAIT: wait for perm_done. On perm_done: buf<=state_in[RATE-1:0], idx<=0 -> STREAM.
//     perm_done in any other state is ignored.
//   DONE: squeeze_done=1 for one cycle; busy=1 -> IDLE.
//  Latency: squeeze_start at cycle T -> out_valid at T+1.
//   Last handshake at T -> squeeze_done at T+1, IDLE (busy=0) at T+2.
//   perm_done at T -> out_valid at T+1.
//  squeeze_start outside IDLE is ignored (no restart, no error).
//  Request spans blocks: word k comes from block k/WPB, lane k%WPB.
//   Total perm_req pulses = ceil(len/WPB)-1.
//  Initial block is not permuted by this block. Caller presents the post-absorb permuted state on state_in with squeeze_start.
//  rem is LEN_WIDTH bits; max request 2^LEN_WIDTH-1 words; no wrap.
//  idx wraps WPB-1 -> 0 only through PERM_REQ/PERM_WAIT, never directly.
//  state_in is sampled only on the capture edges above; it may change freely at all other times.
// STRUCTURE
//  shake_pkg: RATE/STATE_WIDTH/WORD_WIDTH default constants, WPB localparam, sq_state_t enum {IDLE,STREAM,PERM_REQ,PERM_WAIT,DONE}.
//  One sub-module: squeeze_word_mux (combinational buf + idx -> out_word lane select). The rest is a single FSM/datapath.
// TESTING
//  1. len=5, out_ready=1, state_in rate lanes = 0..16 -> words 0,1,2,3,4 on T+1..T+5; out_last on word 4; squeeze_done T+6; no perm_req.
//  2. len=17 -> 17 words, zero perm_req; len=18 -> one perm_req after word 16; bench drives perm_done 24 cycles later with new lanes 100..116 -> word 17 = 100.
//  3. len=40, random out_ready backpressure -> out_word/out_last stable while stalled; 2 perm_req; exactly 40 handshakes; squeeze_done once.
//  4. len=0 -> no out_valid, squeeze_done at T+1, busy low at T+2.
//  5. squeeze_start pulsed again mid-STREAM with len=3 -> ignored; original count completes. Spurious perm_done in STREAM -> no effect.
//  6. reset_n low during PERM_WAIT -> all outputs 0 next cycle; later perm_done ignored; a new request behaves as in test 1.

Source files
------------

// File: rtl/shake_pkg.sv
// ---------------------------------------------------------------------------
// shake_pkg
// Shared constants and types for the SHAKE squeeze datapath.
//   SHAKE_RATE         rate portion of the Keccak state in bits (SHAKE256)
//   SHAKE_STATE_WIDTH  full Keccak state width in bits
//   SHAKE_WORD_WIDTH   width of one streamed output word (one Keccak lane)
//   SHAKE_LEN_WIDTH    width of the requested output length, in words
//   SHAKE_WPB          words per rate block
//   sq_state_t         squeeze controller states
// ---------------------------------------------------------------------------
package shake_pkg;

    localparam int SHAKE_RATE        = 1088;
    localparam int SHAKE_STATE_WIDTH = 1600;
    localparam int SHAKE_WORD_WIDTH  = 64;
    localparam int SHAKE_LEN_WIDTH   = 16;
    localparam int SHAKE_WPB         = SHAKE_RATE / SHAKE_WORD_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        PERM_REQ,
        PERM_WAIT,
        DONE
    } sq_state_t;

endpackage

// File: rtl/squeeze_word_mux.sv
// ---------------------------------------------------------------------------
// squeeze_word_mux
// Combinational lane select: picks word number idx out of the captured rate
// block, lane 0 in the least significant bits (little-endian lane order).
//   rate_data  in   RATE         captured rate block
//   idx        in   IDX_W        lane index, 0 .. RATE/WORD_WIDTH-1
//   word       out  WORD_WIDTH   selected lane; zero for an out-of-range index
// ---------------------------------------------------------------------------
module squeeze_word_mux
    import shake_pkg::*;
#(
    parameter int RATE       = SHAKE_RATE,
    parameter int WORD_WIDTH = SHAKE_WORD_WIDTH,
    parameter int WPB        = RATE / WORD_WIDTH,
    parameter int IDX_W      = $clog2(WPB)
) (
    input  logic [RATE-1:0]       rate_data,
    input  logic [IDX_W-1:0]      idx,
    output logic [WORD_WIDTH-1:0] word
);

    // A one-hot style compare per lane keeps every index in range, so a
    // non-power-of-two lane count never selects past the top of the block.
    always_comb begin
        word = '0;
        for (int i = 0; i < WPB; i++) begin
            if (idx == IDX_W'(i)) begin
                word = rate_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/squeeze_stream.sv
// ---------------------------------------------------------------------------
// squeeze_stream
// Multi-block SHAKE squeeze engine. Captures the rate part of the Keccak
// state, streams it out one lane per valid/ready handshake and asks the
// permutation core for a fresh state whenever a rate block runs out before
// the requested length has been delivered.
//   clk            in   1            clock, rising edge
//   reset_n        in   1            synchronous reset, active low
//   squeeze_start  in   1            start pulse, only honoured in IDLE
//   out_len_words  in   LEN_WIDTH    requested output length in words
//   state_in       in   STATE_WIDTH  Keccak state from the permutation core
//   perm_req       out  1            one-cycle request to permute again
//   perm_done      in   1            permutation finished, state_in valid
//   out_word       out  WORD_WIDTH   output word
//   out_valid      out  1            out_word valid
//   out_ready      in   1            consumer accepts out_word
//   out_last       out  1            out_word is the final word
//   busy           out  1            engine is not idle
//   squeeze_done   out  1            one-cycle pulse when the request is done
// ---------------------------------------------------------------------------
module squeeze_stream
    import shake_pkg::*;
#(
    parameter int RATE        = SHAKE_RATE,
    parameter int STATE_WIDTH = SHAKE_STATE_WIDTH,
    parameter int WORD_WIDTH  = SHAKE_WORD_WIDTH,
    parameter int LEN_WIDTH   = SHAKE_LEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   squeeze_start,
    input  logic [LEN_WIDTH-1:0]   out_len_words,
    input  logic [STATE_WIDTH-1:0] state_in,
    output logic                   perm_req,
    input  logic                   perm_done,
    output logic [WORD_WIDTH-1:0]  out_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   squeeze_done
);

    localparam int WPB   = RATE / WORD_WIDTH;
    localparam int IDX_W = $clog2(WPB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

    sq_state_t              state_q, state_d;
    logic [RATE-1:0]        rate_buf_q, rate_buf_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   perm_req_q, perm_req_d;
    logic                   busy_q, busy_d;
    logic                   squeeze_done_q, squeeze_done_d;
    logic                   handshake;
    logic [WORD_WIDTH-1:0]  lane_word;

    // The capacity part of the state never leaves this block.
    logic                   unused_capacity;
    assign unused_capacity = ^state_in[STATE_WIDTH-1:RATE];

    // out_valid_q is high exactly while the controller sits in STREAM.
    assign handshake = out_valid_q && out_ready;

    // Next-state and datapath updates. idx stays parked on the last lane
    // after the block is exhausted and is only rewound when a new block
    // arrives, so it never wraps on its own.
    always_comb begin
        state_d    = state_q;
        rate_buf_d = rate_buf_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        unique case (state_q)
            IDLE: begin
                if (squeeze_start) begin
                    rate_buf_d = state_in[RATE-1:0];
                    idx_d      = '0;
                    rem_d      = out_len_words;
                    state_d    = (out_len_words != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (handshake) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = PERM_REQ;
                    end
                end
            end
            PERM_REQ: begin
                state_d = PERM_WAIT;
            end
            PERM_WAIT: begin
                if (perm_done) begin
                    rate_buf_d = state_in[RATE-1:0];
                    idx_d      = '0;
                    state_d    = STREAM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight out of
    // flops; out_last follows the remaining count that STREAM will see.
    always_comb begin
        out_valid_d    = (state_d == STREAM);
        out_last_d     = (state_d == STREAM) && (rem_d == LEN_WIDTH'(1));
        perm_req_d     = (state_d == PERM_REQ);
        squeeze_done_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rate_buf_q     <= '0;
            idx_q          <= '0;
            rem_q          <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            perm_req_q     <= 1'b0;
            busy_q         <= 1'b0;
            squeeze_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rate_buf_q     <= rate_buf_d;
            idx_q          <= idx_d;
            rem_q          <= rem_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            perm_req_q     <= perm_req_d;
            busy_q         <= busy_d;
            squeeze_done_q <= squeeze_done_d;
        end
    end

    squeeze_word_mux #(
        .RATE       (RATE),
        .WORD_WIDTH (WORD_WIDTH),
        .WPB        (WPB),
        .IDX_W      (IDX_W)
    ) u_word_mux (
        .rate_data (rate_buf_q),
        .idx       (idx_q),
        .word      (lane_word)
    );

    // idx and the buffer only move on handshakes or block captures, so the
    // word is stable whenever the consumer stalls.
    assign out_word     = out_valid_q ? lane_word : '0;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign perm_req     = perm_req_q;
    assign busy         = busy_q;
    assign squeeze_done = squeeze_done_q;

endmodule
